// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ==== fifo_read_ctrl | drains len words from the async-FIFO read port to a valid/ready skid buffer | Rev 1.0 ====
module fifo_read_ctrl #(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          r_clk,
  input  logic          r_rstn,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] word_cnt,
  output logic          r_en,
  input  logic          empty,
  input  logic [DW-1:0] r_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
);

  localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued;
  logic          inflight;
  logic [1:0]    skid_cnt;
  logic [DW-1:0] skid_tail;
  logic          pop;
  logic          accept;
  logic          clear_cnt;
  logic          done_nxt;
  logic [2:0]    occupancy;

  assign pop       = m_valid && m_ready;
  // Words that will be held (skid + in-flight) after this cycle's pop.
  assign occupancy = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    r_en      = 1'b0;
    accept    = 1'b0;
    clear_cnt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_cnt = 1'b1;
          if (len == '0) begin
            done_nxt = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        r_en = !empty && (issued != len_q) && (occupancy < 3'd2);
        if (pop && ((word_cnt + CNT_ONE) == len_q)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      done      <= 1'b0;
      word_cnt  <= '0;
      len_q     <= '0;
      issued    <= '0;
      inflight  <= 1'b0;
      skid_cnt  <= 2'd0;
      skid_tail <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      done     <= done_nxt;
      inflight <= r_en;

      if (accept) begin
        len_q  <= len;
        issued <= '0;
      end else if (r_en) begin
        issued <= issued + CNT_ONE;
      end

      if (clear_cnt) begin
        word_cnt <= '0;
      end else if (pop) begin
        word_cnt <= word_cnt + CNT_ONE;
      end

      // The head entry lives directly in m_data so the output is registered.
      case ({inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            m_data <= r_data;
          end else begin
            skid_tail <= r_data;
          end
          skid_cnt <= skid_cnt + 2'd1;
          m_valid  <= 1'b1;
        end
        2'b01: begin
          m_data   <= skid_tail;
          skid_cnt <= skid_cnt - 2'd1;
          m_valid  <= (skid_cnt == 2'd2);
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            m_data <= r_data;
          end else begin
            m_data    <= skid_tail;
            skid_tail <= r_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// tb_fifo_read_ctrl: randomized bench with a queue-based FIFO source and an in-order consumer model.
module tb_fifo_read_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          r_clk = 1'b0;
  logic          r_rstn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] word_cnt;
  logic          r_en;
  logic          empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  bit            prev_ren = 1'b0;
  bit            d_rstn = 1'b0;
  bit            d_start = 1'b0;
  bit            d_ready = 1'b0;
  bit            d_gate = 1'b0;
  logic [LW-1:0] d_len = '0;

  always #5 r_clk = ~r_clk;

  fifo_read_ctrl #(.DW(DW), .LW(LW)) dut (
    .r_clk   (r_clk),
    .r_rstn  (r_rstn),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .word_cnt(word_cnt),
    .r_en    (r_en),
    .empty   (empty),
    .r_data  (r_data),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
  );

  // One clock cycle: the FIFO model serves last cycle's read, inputs are applied,
  // and outputs are left settled for the caller to inspect before the next edge.
  task automatic tick();
    @(negedge r_clk);
    if (prev_ren && fq.size() > 0) r_data = fq.pop_front();
    r_rstn  = d_rstn;
    start   = d_start;
    len     = d_len;
    m_ready = d_ready;
    empty   = (fq.size() == 0) || d_gate;
    #1;
    prev_ren = r_en;
  endtask

  task automatic preload(input int n);
    fq.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      fq.push_back($urandom);
      exp_q.push_back(fq[i]);
    end
  endtask

  task automatic test_reset();
    d_rstn = 1'b0; d_start = 1'b0; d_len = '0; d_ready = 1'b1; d_gate = 1'b0;
    preload(4);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({busy, done, r_en, m_valid} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctrl: got busy/done/r_en/m_valid=%b expected 0000", {busy, done, r_en, m_valid});
      end
      checks++;
      if (word_cnt !== '0 || m_data !== '0) begin
        failures++;
        $display("FAIL reset_data: got word_cnt=%0h m_data=%0h expected 0/0", word_cnt, m_data);
      end
    end
    d_rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (r_en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_read: got r_en=%b busy=%b expected 0/0", r_en, busy);
      end
    end
    checks++;
    if (fq.size() != 4) begin
      failures++;
      $display("FAIL idle_fifo_level: got %0d expected 4", fq.size());
    end
  endtask

  task automatic test_streaming();
    int rens = 0, hs = 0, dones = 0, first_ren = -1, last_hs = -1, done_c = -1;
    fq.delete();
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    d_ready = 1'b1; d_gate = 1'b0; d_start = 1'b1; d_len = 16'd8;
    tick();
    d_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1 || r_en !== 1'b1) begin
          failures++;
          $display("FAIL stream_first_cycle: got busy=%b r_en=%b expected 1/1", busy, r_en);
        end
      end
      if (r_en) begin
        rens++;
        if (first_ren < 0) first_ren = c;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== DW'(hs + 1)) begin
          failures++;
          $display("FAIL stream_data: got %0h expected %0h", m_data, hs + 1);
        end
        if (hs > 0) begin
          checks++;
          if (c != last_hs + 1) begin
            failures++;
            $display("FAIL stream_gap: got handshake cycle %0d expected %0d", c, last_hs + 1);
          end
        end
        hs++;
        last_hs = c;
      end
      if (done) begin
        dones++;
        done_c = c;
        checks++;
        if (c != last_hs + 1 || busy !== 1'b0 || hs != 8) begin
          failures++;
          $display("FAIL stream_done: got cycle=%0d busy=%b words=%0d expected cycle=%0d busy=0 words=8",
                   c, busy, hs, last_hs + 1);
        end
      end
      if (done_c > 0 && c > done_c + 3) break;
    end
    checks++;
    if (dones != 1 || rens != 8 || word_cnt !== 16'd8) begin
      failures++;
      $display("FAIL stream_totals: got done=%0d r_en=%0d word_cnt=%0d expected 1/8/8", dones, rens, word_cnt);
    end
    checks++;
    if (last_hs != first_ren + 9) begin
      failures++;
      $display("FAIL stream_latency: got last handshake %0d expected %0d", last_hs, first_ren + 9);
    end
  endtask

  task automatic test_backpressure();
    int reads = 0, hs = 0, dones = 0, done_c = -1, p;
    bit stall_prev = 1'b0;
    logic [DW-1:0] held = '0;
    bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    preload(6);
    exp_q = exp_q[0:3];
    d_gate = 1'b0; d_ready = 1'b0; d_start = 1'b1; d_len = 16'd4;
    tick();
    d_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      d_ready = pattern[c % 4];
      tick();
      p = (m_valid && m_ready) ? 1 : 0;
      if (r_en) begin
        checks++;
        if (reads - hs - p >= 2) begin
          failures++;
          $display("FAIL bp_outstanding: got %0d held with read expected at most 1", reads - hs - p);
        end
        reads++;
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          failures++;
          $display("FAIL bp_stable: got valid=%b data=%0h expected 1/%0h", m_valid, m_data, held);
        end
      end
      if (p == 1) begin
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          failures++;
          $display("FAIL bp_data: got %0h expected next queued word", m_data);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs++;
      end
      stall_prev = m_valid && !m_ready;
      held = m_data;
      if (done) begin
        dones++;
        done_c = c;
      end
      if (done_c >= 0 && c > done_c + 3) break;
    end
    checks++;
    if (dones != 1 || hs != 4 || reads != 4 || fq.size() != 2 || word_cnt !== 16'd4) begin
      failures++;
      $display("FAIL bp_totals: got done=%0d words=%0d reads=%0d left=%0d word_cnt=%0d expected 1/4/4/2/4",
               dones, hs, reads, fq.size(), word_cnt);
    end
  endtask

  task automatic test_empty_gating();
    int reads = 0, hs = 0, dones = 0, done_c = -1;
    preload(5);
    d_ready = 1'b1; d_gate = 1'b0; d_start = 1'b1; d_len = 16'd5;
    tick();
    d_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      d_gate = ((c / 3) % 2) == 1;
      tick();
      if (r_en) begin
        reads++;
        checks++;
        if (empty) begin
          failures++;
          $display("FAIL gate_read_empty: got r_en=1 with empty=1 expected r_en=0");
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          failures++;
          $display("FAIL gate_data: got %0h expected next queued word", m_data);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs++;
      end
      if (done) begin
        dones++;
        done_c = c;
      end
      if (done_c >= 0 && c > done_c + 3) break;
    end
    d_gate = 1'b0;
    checks++;
    if (dones != 1 || hs != 5 || reads != 5) begin
      failures++;
      $display("FAIL gate_totals: got done=%0d words=%0d reads=%0d expected 1/5/5", dones, hs, reads);
    end
  endtask

  task automatic test_zero_len_and_ignored_start();
    int hs = 0, dones = 0, done_c = -1;
    fq.delete();
    d_ready = 1'b1; d_gate = 1'b0; d_start = 1'b1; d_len = '0;
    tick();
    d_start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_cnt !== '0) begin
      failures++;
      $display("FAIL zero_len_done: got done=%b busy=%b word_cnt=%0d expected 1/0/0", done, busy, word_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_pulse: got done=%b busy=%b expected 0/0", done, busy);
    end
    preload(8);
    exp_q = exp_q[0:5];
    d_start = 1'b1; d_len = 16'd6;
    tick();
    d_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      d_start = (c == 3);
      d_len = (c == 3) ? 16'd3 : 16'd6;
      tick();
      if (c == 4) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL ignored_start_busy: got busy=%b expected 1", busy);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          failures++;
          $display("FAIL ignored_start_data: got %0h expected next queued word", m_data);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        hs++;
      end
      if (done) begin
        dones++;
        done_c = c;
      end
      if (done_c >= 0 && c > done_c + 3) break;
    end
    d_start = 1'b0;
    checks++;
    if (dones != 1 || hs != 6 || word_cnt !== 16'd6 || fq.size() != 2) begin
      failures++;
      $display("FAIL ignored_start_totals: got done=%0d words=%0d word_cnt=%0d left=%0d expected 1/6/6/2",
               dones, hs, word_cnt, fq.size());
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    preload(6);
    d_ready = 1'b1; d_gate = 1'b0; d_start = 1'b1; d_len = 16'd6;
    tick();
    d_start = 1'b0;
    while (word_cnt != 16'd2 && guard < 30) begin
      tick();
      guard++;
    end
    checks++;
    if (word_cnt !== 16'd2) begin
      failures++;
      $display("FAIL mid_reach_two: got word_cnt=%0d expected 2", word_cnt);
    end
    d_rstn = 1'b0;
    tick();
    d_rstn = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== '0 || done !== 1'b0 || r_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state: got valid=%b busy=%b word_cnt=%0d done=%b r_en=%b expected 0/0/0/0/0",
               m_valid, busy, word_cnt, done, r_en);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet: got done=%b busy=%b valid=%b expected 0/0/0", done, busy, m_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n, reads = 0, hs = 0, dones = 0, done_c = -1, last_hs = -1, p;
      bit stall_prev = 1'b0;
      logic [DW-1:0] held = '0;
      n = $urandom_range(1, 12);
      preload(n + $urandom_range(0, 3));
      exp_q = exp_q[0:n-1];
      d_gate = 1'b0; d_ready = 1'b1; d_start = 1'b1; d_len = LW'(n);
      tick();
      d_start = 1'b0;
      for (int c = 0; c < 400; c++) begin
        d_ready = ($urandom % 4) != 0;
        d_gate  = ($urandom % 5) == 0;
        tick();
        p = (m_valid && m_ready) ? 1 : 0;
        if (r_en) begin
          checks++;
          if (empty || reads - hs - p >= 2 || reads >= n) begin
            failures++;
            $display("FAIL rand_read: got empty=%b outstanding=%0d reads=%0d len=%0d", empty, reads - hs - p, reads, n);
          end
          reads++;
        end
        if (stall_prev) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== held) begin
            failures++;
            $display("FAIL rand_stable: got valid=%b data=%0h expected 1/%0h", m_valid, m_data, held);
          end
        end
        if (p == 1) begin
          checks++;
          if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
            failures++;
            $display("FAIL rand_data: got %0h expected next queued word", m_data);
          end
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs++;
          last_hs = c;
        end
        stall_prev = m_valid && !m_ready;
        held = m_data;
        if (done) begin
          dones++;
          done_c = c;
          checks++;
          if (c != last_hs + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_done_timing: got cycle=%0d busy=%b expected cycle=%0d busy=0", c, busy, last_hs + 1);
          end
        end
        if (done_c >= 0 && c > done_c + 2) break;
      end
      d_gate = 1'b0;
      checks++;
      if (dones != 1 || hs != n || reads != n || word_cnt !== LW'(n)) begin
        failures++;
        $display("FAIL rand_totals: got done=%0d words=%0d reads=%0d word_cnt=%0d expected 1/%0d/%0d/%0d",
                 dones, hs, reads, word_cnt, n, n, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_gating();
    test_zero_len_and_ignored_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
